// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Control unit for the multi-cycle MIPS-subset processor. It takes op/funct
// from the datapath's instruction register and drives every datapath
// select and write-enable from a Moore state machine, one microstep per
// mCLK cycle.
//
// Outputs are registered. On each edge they are loaded with the decode of
// the state being entered, so they always equal the decode of the current
// state. While RST is high the state is FETCH and every output is 0. The
// first edge after RST falls does not advance the state. Instead it loads
// the FETCH outputs, so FETCH fills the first full cycle after reset.
//
// Optional feature, macro MC_CTRL_ILLEGAL_TRAP_EN:
//   defined   - adds the 'illegal' output and a HALT state. An unknown op or
//               an unsupported R-type funct traps into HALT. HALT holds with
//               illegal=1 until RST.
//   undefined - no 'illegal' port. Unknown encodings fall back to FETCH as
//               NOPs, with no write enables raised.
//
// Ports:
//   mCLK       in  1  system clock, rising edge
//   RST        in  1  asynchronous active-high reset
//   op         in  6  IR[31:26]
//   funct      in  6  IR[5:0]
//   MtoRFSel   out 1  RF write data: 0 ALUOUTR, 1 DR
//   RFDSel     out 1  RF write address: 0 rt, 1 rd
//   IDSel      out 1  memory address: 0 PC, 1 ALUOUTR
//   ALUIn1Sel  out 1  ALU input 1: 0 PC, 1 A
//   IRWE       out 1  IR load enable
//   DMWE       out 1  memory write enable
//   PCWE       out 1  unconditional PC write
//   Branch     out 1  PC write when the ALU zero flag is set
//   RFWE       out 1  register-file write enable
//   PCSel      out 2  00 ALUOUT, 01 ALUOUTR, 10 jump address
//   ALUIn2Sel  out 2  00 B, 01 constant 1, 10 SImm
//   ALUSel     out 3  010 add, 110 sub, 000 and, 001 or, 111 slt
//   illegal    out 1  trap flag (only with MC_CTRL_ILLEGAL_TRAP_EN)

module multicycle_controller (
    input  logic       mCLK,
    input  logic       RST,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       MtoRFSel,
    output logic       RFDSel,
    output logic       IDSel,
    output logic       ALUIn1Sel,
    output logic       IRWE,
    output logic       DMWE,
    output logic       PCWE,
    output logic       Branch,
    output logic       RFWE,
    output logic [1:0] PCSel,
    output logic [1:0] ALUIn2Sel,
    output logic [2:0] ALUSel
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_ADDIEXE = 4'd8,
        S_ADDIWB  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ,
        S_HALT    = 4'd12
`endif
    } state_t;

    // One bundle holding every control output, so the registered copy and
    // its next value move together.
    typedef struct packed {
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
        logic       mtoRFSel;
        logic       rfdSel;
        logic       idSel;
        logic       aluIn1Sel;
        logic       irWe;
        logic       dmWe;
        logic       pcWe;
        logic       branch;
        logic       rfWe;
        logic [1:0] pcSel;
        logic [1:0] aluIn2Sel;
        logic [2:0] aluSel;
    } ctrl_t;

    state_t r_state;
    ctrl_t  r_ctrl;
    logic   r_running;
    logic   r_isStore;

    state_t w_nextState;
    ctrl_t  w_loadCtrl;

    // R-type funct codes this datapath can execute.
    function automatic logic functSupported(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

    // ALU operation for an R-type funct. Unsupported codes fall back to add.
    // The result is harmless because no write follows them.
    function automatic logic [2:0] functToAlu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Moore output decode. A state not listed here leaves every output at 0.
    // EXECUTE is the only state whose outputs depend on anything else,
    // because its ALU operation comes from funct.
    function automatic ctrl_t decodeCtrl(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irWe      = 1'b1;
                c.aluIn2Sel = 2'b01;
                c.aluSel    = 3'b010;
                c.pcWe      = 1'b1;
            end
            S_DECODE: begin
                c.aluIn2Sel = 2'b10;
                c.aluSel    = 3'b010;
            end
            S_MEMADR, S_ADDIEXE: begin
                c.aluIn1Sel = 1'b1;
                c.aluIn2Sel = 2'b10;
                c.aluSel    = 3'b010;
            end
            S_MEMRD: c.idSel = 1'b1;
            S_MEMWB: begin
                c.mtoRFSel = 1'b1;
                c.rfWe     = 1'b1;
            end
            S_MEMWR: begin
                c.idSel = 1'b1;
                c.dmWe  = 1'b1;
            end
            S_EXECUTE: begin
                c.aluIn1Sel = 1'b1;
                c.aluSel    = functToAlu(f);
            end
            S_ALUWB: begin
                c.rfdSel = 1'b1;
                c.rfWe   = 1'b1;
            end
            S_ADDIWB: c.rfWe = 1'b1;
            S_BRANCH: begin
                c.aluIn1Sel = 1'b1;
                c.aluSel    = 3'b110;
                c.branch    = 1'b1;
                c.pcSel     = 2'b01;
            end
            S_JUMP: begin
                c.pcSel = 2'b10;
                c.pcWe  = 1'b1;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_HALT: c.illegal = 1'b1;
`endif
            default: ;
        endcase
        return c;
    endfunction

    // Next-state logic. op is read in DECODE and funct in EXECUTE. MEMADR
    // uses the lw/sw flag captured in DECODE instead of reading op again.
    always_comb begin
        w_nextState = S_FETCH;
        case (r_state)
            S_FETCH:  w_nextState = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_nextState = S_MEMADR;
                    OP_RTYPE:     w_nextState = S_EXECUTE;
                    OP_BEQ:       w_nextState = S_BRANCH;
                    OP_ADDI:      w_nextState = S_ADDIEXE;
                    OP_J:         w_nextState = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:      w_nextState = S_HALT;
`else
                    default:      w_nextState = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:  w_nextState = r_isStore ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_nextState = S_MEMWB;
            S_EXECUTE: begin
                if (functSupported(funct)) begin
                    w_nextState = S_ALUWB;
                end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    w_nextState = S_HALT;
`else
                    w_nextState = S_FETCH;
`endif
                end
            end
            S_ADDIEXE: w_nextState = S_ADDIWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_HALT:    w_nextState = S_HALT;
`endif
            default:   w_nextState = S_FETCH;
        endcase
    end

    // Value loaded into the output register. The first edge after reset
    // reloads FETCH outputs without advancing. Every later edge loads the
    // decode of the state being entered.
    always_comb begin
        w_loadCtrl = decodeCtrl(S_FETCH, funct);
        if (r_running) begin
            w_loadCtrl = decodeCtrl(w_nextState, funct);
        end
    end

    // The state machine: state, registered outputs, post-reset start flag,
    // and the lw/sw flag captured in DECODE. Reset clears the outputs at
    // once, so an interrupted instruction cannot complete its write.
    always_ff @(posedge mCLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_FETCH;
            r_ctrl    <= '0;
            r_running <= 1'b0;
            r_isStore <= 1'b0;
        end else begin
            r_running <= 1'b1;
            r_ctrl    <= w_loadCtrl;
            if (r_running) begin
                r_state <= w_nextState;
                if (r_state == S_DECODE) begin
                    r_isStore <= (op == OP_SW);
                end
            end
        end
    end

    assign MtoRFSel  = r_ctrl.mtoRFSel;
    assign RFDSel    = r_ctrl.rfdSel;
    assign IDSel     = r_ctrl.idSel;
    assign ALUIn1Sel = r_ctrl.aluIn1Sel;
    assign IRWE      = r_ctrl.irWe;
    assign DMWE      = r_ctrl.dmWe;
    assign PCWE      = r_ctrl.pcWe;
    assign Branch    = r_ctrl.branch;
    assign RFWE      = r_ctrl.rfWe;
    assign PCSel     = r_ctrl.pcSel;
    assign ALUIn2Sel = r_ctrl.aluIn2Sel;
    assign ALUSel    = r_ctrl.aluSel;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal   = r_ctrl.illegal;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
// Testbench for multicycle_controller. A stimulus process drives op/funct
// one instruction at a time and queues the expected output vector for every
// cycle of that instruction. A monitor pops one entry per cycle on the
// falling clock edge and compares it with the outputs.

module tb_multicycle_controller;

    localparam int S_FETCH   = 0;
    localparam int S_DECODE  = 1;
    localparam int S_MEMADR  = 2;
    localparam int S_MEMRD   = 3;
    localparam int S_MEMWB   = 4;
    localparam int S_MEMWR   = 5;
    localparam int S_EXECUTE = 6;
    localparam int S_ALUWB   = 7;
    localparam int S_ADDIEXE = 8;
    localparam int S_ADDIWB  = 9;
    localparam int S_BRANCH  = 10;
    localparam int S_JUMP    = 11;
    localparam int S_HALT    = 12;

    typedef struct {
        logic [16:0] expVec;
        logic [16:0] mask;
        string       tag;
    } expEntry_t;

    logic       mCLK;
    logic       RST;
    logic [5:0] op;
    logic [5:0] funct;
    logic       MtoRFSel, RFDSel, IDSel, ALUIn1Sel, IRWE, DMWE, PCWE, Branch, RFWE;
    logic [1:0] PCSel, ALUIn2Sel;
    logic [2:0] ALUSel;
    logic       illegalObs;
    logic [16:0] obsVec;

    expEntry_t expQ[$];
    bit        monitorOn;
    int        checks;
    int        errors;

    multicycle_controller dut (
        .mCLK      (mCLK),
        .RST       (RST),
        .op        (op),
        .funct     (funct),
        .MtoRFSel  (MtoRFSel),
        .RFDSel    (RFDSel),
        .IDSel     (IDSel),
        .ALUIn1Sel (ALUIn1Sel),
        .IRWE      (IRWE),
        .DMWE      (DMWE),
        .PCWE      (PCWE),
        .Branch    (Branch),
        .RFWE      (RFWE),
        .PCSel     (PCSel),
        .ALUIn2Sel (ALUIn2Sel),
        .ALUSel    (ALUSel)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal   (illegalObs)
`endif
    );

`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegalObs = 1'b0;
`endif

    // Pack all outputs in one fixed order so a single compare covers them.
    always_comb begin
        obsVec = {illegalObs, MtoRFSel, RFDSel, IDSel, ALUIn1Sel, IRWE, DMWE,
                  PCWE, Branch, RFWE, PCSel, ALUIn2Sel, ALUSel};
    end

    // 10 ns clock with rising edges at 5, 15, 25, ...
    initial begin
        mCLK = 1'b0;
        forever #5 mCLK = ~mCLK;
    end

    // Hard stop so a hung run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison, and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [16:0] observed,
                               input logic [16:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %05h, expected %05h", tag, observed, expected);
        end
    endtask

    function automatic bit functOk(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    // Expected outputs for each state, taken from the state's output list.
    function automatic logic [16:0] expVecFor(input int st, input logic [5:0] f);
        logic       ill, mto, rfd, ids, in1, irwe, dmwe, pcwe, br, rfwe;
        logic [1:0] pcs, in2;
        logic [2:0] alu;
        {ill, mto, rfd, ids, in1, irwe, dmwe, pcwe, br, rfwe} = '0;
        pcs = 2'b00;
        in2 = 2'b00;
        alu = 3'b000;
        case (st)
            S_FETCH:   begin irwe = 1; in2 = 2'b01; alu = 3'b010; pcwe = 1; end
            S_DECODE:  begin in2 = 2'b10; alu = 3'b010; end
            S_MEMADR,
            S_ADDIEXE: begin in1 = 1; in2 = 2'b10; alu = 3'b010; end
            S_MEMRD:   ids = 1;
            S_MEMWB:   begin mto = 1; rfwe = 1; end
            S_MEMWR:   begin ids = 1; dmwe = 1; end
            S_EXECUTE: begin
                in1 = 1;
                case (f)
                    6'b100000: alu = 3'b010;
                    6'b100010: alu = 3'b110;
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b101010: alu = 3'b111;
                    default:   alu = 3'b000;
                endcase
            end
            S_ALUWB:   begin rfd = 1; rfwe = 1; end
            S_ADDIWB:  rfwe = 1;
            S_BRANCH:  begin in1 = 1; alu = 3'b110; br = 1; pcs = 2'b01; end
            S_JUMP:    begin pcs = 2'b10; pcwe = 1; end
            S_HALT:    ill = 1;
            default:   ;
        endcase
        return {ill, mto, rfd, ids, in1, irwe, dmwe, pcwe, br, rfwe, pcs, in2, alu};
    endfunction

    // Called one time unit after the rising edge that starts an instruction's
    // FETCH cycle. Queues the expected per-cycle outputs, drives the
    // instruction fields, then waits until just after the next FETCH starts.
    // With keep > 0, only the first 'keep' cycles are queued, and the task
    // returns inside the last of them.
    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input int keep);
        int        states[$];
        int        nWait;
        expEntry_t e;
        states = {S_FETCH, S_DECODE};
        case (o)
            6'b100011: states = {states, S_MEMADR, S_MEMRD, S_MEMWB};
            6'b101011: states = {states, S_MEMADR, S_MEMWR};
            6'b000000: begin
                states.push_back(S_EXECUTE);
                if (functOk(f)) states.push_back(S_ALUWB);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                else states.push_back(S_HALT);
`endif
            end
            6'b000100: states.push_back(S_BRANCH);
            6'b001000: states = {states, S_ADDIEXE, S_ADDIWB};
            6'b000010: states.push_back(S_JUMP);
            default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                states.push_back(S_HALT);
`endif
            end
        endcase
        if (states[states.size()-1] == S_HALT) begin
            for (int k = 0; k < 9; k++) states.push_back(S_HALT);
        end
        if (keep > 0) begin
            while (states.size() > keep) void'(states.pop_back());
        end
        foreach (states[i]) begin
            e.expVec = expVecFor(states[i], f);
            e.mask   = (states[i] == S_EXECUTE && !functOk(f)) ? 17'h1FFF8 : 17'h1FFFF;
            e.tag    = $sformatf("op%b_f%b_cyc%0d", o, f, i + 1);
            expQ.push_back(e);
        end
        op    = o;
        funct = f;
        nWait = (keep > 0) ? states.size() - 1 : states.size();
        repeat (nWait) @(posedge mCLK);
        #1;
        if (states[states.size()-1] == S_HALT) begin
            // Still halted. Pulse reset, then resume at the next FETCH.
            monitorOn = 1'b0;
            checkOutput("haltHeld", obsVec, 17'h10000);
            RST = 1'b1;
            #1;
            checkOutput("haltReset", obsVec, 17'h00000);
            RST = 1'b0;
            @(posedge mCLK);
            #1;
            monitorOn = 1'b1;
        end
    endtask

    // Scoreboard monitor: one expected vector per cycle, sampled on the
    // falling edge. Also checks the write-enable and PC-write exclusions.
    always @(negedge mCLK) begin
        if (monitorOn) begin
            if (expQ.size() == 0) begin
                checkOutput("queueDepth", 17'(expQ.size()), 17'd1);
            end else begin
                expEntry_t e;
                e = expQ.pop_front();
                checkOutput(e.tag, obsVec & e.mask, e.expVec & e.mask);
            end
            checkOutput("dmweRfweExcl", {16'd0, DMWE & RFWE}, 17'd0);
            checkOutput("pcweBranchExcl", {16'd0, PCWE & Branch}, 17'd0);
        end
    end

    // Main sequence: reset, directed instructions, a NOP/illegal op, an
    // unsupported funct, reset in the middle of a lw, then a short random mix.
    initial begin
        logic [5:0] opTab[8];
        logic [5:0] functTab[8];
        int         pick;
        opTab    = '{6'b100011, 6'b101011, 6'b000000, 6'b000000,
                     6'b000000, 6'b000100, 6'b001000, 6'b000010};
        functTab = '{6'b000000, 6'b000000, 6'b100000, 6'b100101,
                     6'b101010, 6'b000000, 6'b000000, 6'b000000};
        checks    = 0;
        errors    = 0;
        monitorOn = 1'b0;
        RST   = 1'b1;
        op    = 6'b000000;
        funct = 6'b000000;
        #2;
        checkOutput("resetActive", obsVec, 17'h00000);
        #16;
        RST = 1'b0;
        #1;
        checkOutput("resetReleased", obsVec, 17'h00000);
        @(posedge mCLK);
        #1;
        monitorOn = 1'b1;

        applyStimulus(6'b100011, 6'b000000, 0);   // lw
        applyStimulus(6'b000000, 6'b100010, 0);   // sub
        applyStimulus(6'b000000, 6'b100000, 0);   // add
        applyStimulus(6'b000000, 6'b100100, 0);   // and
        applyStimulus(6'b000000, 6'b100101, 0);   // or
        applyStimulus(6'b000000, 6'b101010, 0);   // slt
        applyStimulus(6'b000100, 6'b000000, 0);   // beq
        applyStimulus(6'b101011, 6'b000000, 0);   // sw
        applyStimulus(6'b000010, 6'b000000, 0);   // j
        applyStimulus(6'b001000, 6'b000000, 0);   // addi
        applyStimulus(6'b111111, 6'b000000, 0);   // unknown op
        applyStimulus(6'b000000, 6'b000000, 0);   // unsupported funct

        // lw interrupted by a 1 ns reset pulse during MEMRD.
        applyStimulus(6'b100011, 6'b000000, 4);
        @(negedge mCLK);
        #1;
        RST = 1'b1;
        #0.5;
        checkOutput("midResetOutputs", obsVec, 17'h00000);
        #0.5;
        RST = 1'b0;
        @(posedge mCLK);
        #1;

        applyStimulus(6'b000010, 6'b000000, 0);   // j after recovery

        for (int n = 0; n < 8; n++) begin
            pick = $urandom_range(0, 7);
            applyStimulus(opTab[pick], functTab[pick], 0);
        end

        monitorOn = 1'b0;
        checkOutput("queueEmpty", 17'(expQ.size()), 17'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multi-cycle MIPS-subset processor, the other end of the datapath's control interface. It consumes `op`/`funct` from the datapath's instruction register and drives every datapath select and write-enable through a Moore state machine, one microstep per `mCLK`. It sits beside the datapath at the top level, clocked by the same `mCLK` and reset by the same `RST`.

## Interface
- No parameters.
- `mCLK` in 1: system clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `op` in 6: `IR[31:26]`.
- `funct` in 6: `IR[5:0]`.
- `MtoRFSel` out 1: 0 selects ALUOUTR as register-file write data, 1 selects DR.
- `RFDSel` out 1: 0 selects rt as write address, 1 selects rd.
- `IDSel` out 1: 0 selects PC as memory address, 1 selects ALUOUTR.
- `ALUIn1Sel` out 1: 0 selects PC as ALU input 1, 1 selects A.
- `IRWE` out 1: IR load enable.
- `DMWE` out 1: memory write enable.
- `PCWE` out 1: unconditional PC write.
- `Branch` out 1: conditional PC write, taken when the ALU zero flag is set.
- `RFWE` out 1: register-file write enable.
- `PCSel` out 2: 00 ALUOUT, 01 ALUOUTR, 10 jump address.
- `ALUIn2Sel` out 2: 00 B, 01 constant 1, 10 SImm.
- `ALUSel` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal` out 1: exists only with `MC_CTRL_ILLEGAL_TRAP_EN` (see Configuration).

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Supported R-type funct values map to `ALUSel` as follows: add 100000→010, sub 100010→110, and 100100→000, or 100101→001, slt 101010→111.
- The state register is 4 bits. Outputs decode from the state only. Next state decodes from the state plus `op`/`funct`.
- Any output not listed for a state is 0.

States and their outputs:
- FETCH: IRWE=1, IDSel=0, ALUIn1Sel=0, ALUIn2Sel=01, ALUSel=010, PCSel=00, PCWE=1. Next state is DECODE.
- DECODE: ALUIn1Sel=0, ALUIn2Sel=10, ALUSel=010. This precomputes the branch target PC+1+SImm into ALUOUTR. Next state by `op`:
  - lw/sw → MEMADR
  - R-type → EXECUTE
  - beq → BRANCH
  - addi → ADDIEXE
  - j → JUMP
  - any other op → FETCH (NOP)
- MEMADR and ADDIEXE: ALUIn1Sel=1, ALUIn2Sel=10, ALUSel=010. MEMADR goes to MEMRD if lw, MEMWR if sw. ADDIEXE goes to ADDIWB.
- MEMRD: IDSel=1. Next state is MEMWB.
- MEMWB: RFDSel=0, MtoRFSel=1, RFWE=1. Next state is FETCH.
- MEMWR: IDSel=1, DMWE=1. Next state is FETCH.
- EXECUTE: ALUIn1Sel=1, ALUIn2Sel=00, ALUSel from `funct`. Next state is ALUWB for a supported funct, FETCH for an unsupported one (no write).
- ALUWB: RFDSel=1, MtoRFSel=0, RFWE=1. Next state is FETCH.
- ADDIWB: RFDSel=0, MtoRFSel=0, RFWE=1. Next state is FETCH.
- BRANCH: ALUIn1Sel=1, ALUIn2Sel=00, ALUSel=110, Branch=1, PCSel=01. Next state is FETCH.
- JUMP: PCSel=10, PCWE=1. Next state is FETCH.
- Unused state encodings go to FETCH on the next edge, with all outputs 0.

## Timing
- While `RST` is high, the state is forced to FETCH asynchronously and all outputs are forced to 0, including `illegal`.
- The first FETCH outputs appear in the first full cycle after `RST` deasserts.
- Cycles per instruction:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
  - illegal op or unsupported funct: 2 or 3 cycles, no architectural write.
- `op`/`funct` are sampled only in DECODE and EXECUTE. IR changes only at the end of FETCH.
- Exactly one of PCWE/Branch is asserted in any state, or neither.
- DMWE and RFWE are never asserted in the same cycle.
- If `RST` asserts mid-instruction, the instruction is abandoned and no partial write occurs after the assertion.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - Adds the `illegal` output and a HALT state.
  - An unknown op in DECODE goes to HALT instead of FETCH.
  - In HALT, `illegal`=1 and all other outputs are 0. HALT is held until `RST`.
  - An unsupported funct also goes to HALT.
- `MC_CTRL_ILLEGAL_TRAP_EN` undefined: no `illegal` port and no HALT state. Illegal encodings behave as NOPs, as described in Operation.

## Test plan
- Reset then `op`=100011 in DECODE → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. RFWE=1 and MtoRFSel=1 only in cycle 5, IRWE=1 only in cycle 1.
- `op`=000000, `funct`=100010 → EXECUTE drives ALUSel=110, ALUIn2Sel=00. ALUWB drives RFWE=1, RFDSel=1. Back in FETCH at cycle 5.
- `op`=000100 → BRANCH drives Branch=1, PCWE=0, PCSel=01, ALUSel=110. Next FETCH at cycle 4.
- `op`=101011 → MEMWR drives DMWE=1, IDSel=1, RFWE=0. Then `op`=000010 → JUMP drives PCSel=10, PCWE=1.
- `op`=111111: without the macro, FETCH follows DECODE with no write enables. With the macro, `illegal`=1 stays set over 10 cycles, then clears on `RST`.
- `RST` pulsed for 1 ns in the MEMRD cycle of a lw → all outputs 0 immediately, MEMWB never reached, FETCH follows deassertion.
